// File: rtl/count_display_pkg.sv
// count_display_pkg: shared types and constants for the count display driver
package count_display_pkg;
  localparam int BCD_W      = 4;
  localparam int NUM_DIGITS = 3;
  localparam int ITERS      = 8;
  typedef enum logic [1:0] {IDLE, CONVERT, LATCH} state_t;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [2:0] AN_0      = 3'b110;
  localparam logic [2:0] AN_1      = 3'b101;
  localparam logic [2:0] AN_2      = 3'b011;
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction
endpackage

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: combinational BCD nibble to active-low {g,f,e,d,c,b,a} decoder
module bcd_to_seg7
  import count_display_pkg::*;
(
  input  logic [BCD_W-1:0] i_bcd,
  output logic [6:0]       o_seg
);
  // Values above 9 cannot come from a valid conversion and show as dark
  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0: o_seg = SEG_0;
      4'd1: o_seg = SEG_1;
      4'd2: o_seg = SEG_2;
      4'd3: o_seg = SEG_3;
      4'd4: o_seg = SEG_4;
      4'd5: o_seg = SEG_5;
      4'd6: o_seg = SEG_6;
      4'd7: o_seg = SEG_7;
      4'd8: o_seg = SEG_8;
      4'd9: o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/count_display_driver.sv
// count_display_driver: double-dabble BCD conversion of Count driving a 3-digit muxed common-anode display; COUNT_DISPLAY_LZ_BLANK_EN enables leading-zero blanking
module count_display_driver
  import count_display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 8
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [CNT_W-1:0]            Count,
  input  logic                        Load,
  output logic                        Busy,
  output logic                        Done,
  output logic [NUM_DIGITS*BCD_W-1:0] Digits,
  output logic [6:0]                  Seg,
  output logic [2:0]                  Anode
);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int DW = NUM_DIGITS * BCD_W;
  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_shift;
  logic [DW-1:0]         r_bcd;
  logic [DW-1:0]         w_adj;
  logic [2:0]            r_iter;
  logic                  r_done;
  logic [DW-1:0]         r_digits;
  logic [DW-1:0]         w_digits_nxt;
  logic [RW-1:0]         r_ref;
  logic                  w_wrap;
  logic [1:0]            r_idx;
  logic [1:0]            w_idx_nxt;
  logic [BCD_W-1:0]      w_nib;
  logic [6:0]            w_seg_raw;
  logic                  w_blank;
  logic [6:0]            r_seg;
  logic [2:0]            r_anode;

  assign Busy   = r_state != IDLE;
  assign Done   = r_done;
  assign Digits = r_digits;
  assign Seg    = r_seg;
  assign Anode  = r_anode;

  // Next-state logic: Load only matters in IDLE, so loads during CONVERT/LATCH are dropped
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = Load ? CONVERT : IDLE;
      CONVERT: w_state_nxt = (r_iter == 3'(ITERS - 1)) ? LATCH : CONVERT;
      LATCH:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  assign w_adj = {add3(r_bcd[11:8]), add3(r_bcd[7:4]), add3(r_bcd[3:0])};

  // Conversion datapath: one add-3-then-shift step per clock, digits published only at LATCH
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_shift  <= '0;
      r_bcd    <= '0;
      r_iter   <= '0;
      r_done   <= 1'b0;
      r_digits <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (Load) begin
          r_shift <= Count;
          r_bcd   <= '0;
          r_iter  <= '0;
        end
        CONVERT: begin
          {r_bcd, r_shift} <= {w_adj, r_shift} << 1;
          r_iter           <= r_iter + 3'd1;
        end
        LATCH: begin
          r_digits <= r_bcd;
          r_done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Seg/Anode are registered from next-cycle index and digits so they always match Digits and each other
  always_comb begin
    w_wrap       = r_ref == RW'(REFRESH_DIV - 1);
    w_idx_nxt    = w_wrap ? ((r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1) : r_idx;
    w_digits_nxt = (r_state == LATCH) ? r_bcd : r_digits;
    w_nib        = (w_idx_nxt == 2'd0) ? w_digits_nxt[3:0] :
                   (w_idx_nxt == 2'd1) ? w_digits_nxt[7:4] : w_digits_nxt[11:8];
`ifdef COUNT_DISPLAY_LZ_BLANK_EN
    w_blank      = ((w_idx_nxt == 2'd2) && (w_digits_nxt[11:8] == 4'd0)) ||
                   ((w_idx_nxt == 2'd1) && (w_digits_nxt[11:4] == 8'd0));
`else
    w_blank      = 1'b0;
`endif
  end

  bcd_to_seg7 u_dec (
    .i_bcd (w_nib),
    .o_seg (w_seg_raw)
  );

  // Refresh scan: free-running divider steps the digit index; units digit shown at reset
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_ref   <= '0;
      r_idx   <= 2'd0;
      r_seg   <= SEG_0;
      r_anode <= AN_0;
    end else begin
      r_ref   <= w_wrap ? '0 : r_ref + RW'(1);
      r_idx   <= w_idx_nxt;
      r_seg   <= w_blank ? SEG_BLANK : w_seg_raw;
      r_anode <= (w_idx_nxt == 2'd0) ? AN_0 : (w_idx_nxt == 2'd1) ? AN_1 : AN_2;
    end
  end
endmodule

// File: tb/tb_count_display_driver.sv
// tb_count_display_driver: scoreboard bench for count_display_driver
module tb_count_display_driver;
  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        Load = 1'b0;
  logic [7:0]  Count = 8'd0;
  logic        Busy, Done;
  logic [11:0] Digits;
  logic [6:0]  Seg;
  logic [2:0]  Anode;
  int n_chk = 0;
  int n_fail = 0;
  int exp_q[$];
  int m_val = 0;
  int m_pend_val = 0;
  int m_cnt = 0;
  int m_e = 0;
  logic m_pend = 1'b0;
  logic m_done = 1'b0;
  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  always #5 CLK = ~CLK;

  count_display_driver #(.REFRESH_DIV(4)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .Count  (Count),
    .Load   (Load),
    .Busy   (Busy),
    .Done   (Done),
    .Digits (Digits),
    .Seg    (Seg),
    .Anode  (Anode)
  );

  function automatic int to_bcd(int v);
    return (v / 100) * 256 + ((v / 10) % 10) * 16 + v % 10;
  endfunction

  function automatic int exp_an(int idx);
    return idx == 0 ? 3'b110 : idx == 1 ? 3'b101 : 3'b011;
  endfunction

  function automatic int exp_seg(int v, int idx);
    int d;
    bit bl;
    d = idx == 0 ? v % 10 : idx == 1 ? (v / 10) % 10 : v / 100;
    bl = 1'b0;
`ifdef COUNT_DISPLAY_LZ_BLANK_EN
    bl = (idx == 2 && v < 100) || (idx == 1 && v < 10);
`endif
    return bl ? 7'h7F : int'(seg_tab[d]);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a Load is taken only when no conversion is outstanding; result appears 9 edges later
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_val  <= 0;
      m_pend <= 1'b0;
      m_cnt  <= 0;
      m_e    <= 0;
      m_done <= 1'b0;
      exp_q.delete();
    end else begin
      m_e    <= m_e + 1;
      m_done <= 1'b0;
      if (Load && !m_pend) begin
        m_pend     <= 1'b1;
        m_cnt      <= 9;
        m_pend_val <= int'(Count);
        exp_q.push_back(int'(Count));
      end else if (m_pend) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_pend <= 1'b0;
          m_val  <= m_pend_val;
          m_done <= 1'b1;
        end
      end
    end
  end

  // Monitor: status and display every cycle, scoreboard pop on each Done
  always @(negedge CLK) begin
    chk("busy", int'(Busy), int'(m_pend));
    chk("done", int'(Done), int'(m_done));
    chk("digits", int'(Digits), to_bcd(m_val));
    chk("anode", int'(Anode), exp_an((m_e / 4) % 3));
    chk("seg", int'(Seg), exp_seg(m_val, (m_e / 4) % 3));
    if (Done) begin
      chk("sb_nonempty", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) chk("sb_digits", int'(Digits), to_bcd(exp_q.pop_front()));
    end
  end

  task automatic load(input logic [7:0] v);
    @(negedge CLK);
    Load  = 1'b1;
    Count = v;
    @(negedge CLK);
    Load  = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    load(8'd255);
    repeat (12) @(negedge CLK);
    load(8'd0);
    repeat (11) @(negedge CLK);
    load(8'd100);
    repeat (11) @(negedge CLK);
    load(8'd9);
    repeat (11) @(negedge CLK);
    load(8'd37);
    repeat (1) @(negedge CLK);
    load(8'd200);
    repeat (12) @(negedge CLK);
    load(8'd128);
    repeat (30) @(negedge CLK);
    load(8'd255);
    repeat (3) @(negedge CLK);
    #1 RST = 1'b0;
    #1;
    chk("rst_busy", int'(Busy), 0);
    chk("rst_done", int'(Done), 0);
    chk("rst_digits", int'(Digits), 0);
    chk("rst_anode", int'(Anode), 3'b110);
    chk("rst_seg", int'(Seg), 7'h40);
    @(negedge CLK);
    RST = 1'b1;
    load(8'd7);
    repeat (30) @(negedge CLK);
    repeat (400) begin
      @(negedge CLK);
      Load  = ($urandom % 5) == 0;
      Count = 8'($urandom);
    end
    @(negedge CLK);
    Load = 1'b0;
    repeat (15) @(negedge CLK);
    chk("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
